// File: rtl/ci_master_pkg.sv
// rtl/ci_master_pkg.sv - shared FSM encoding, error word and default widths for ci_sample_master
// Optional feature macro: CI_TIMEOUT_EN (adds the ST_ERR state).
// Contents:
//   CI_DATA_W_DEF   default sample / operand / result width
//   CI_TIMEOUT_DEF  default cycles waited for ci_done
//   CI_OP_CNT_W     width of the completed-operation counter
//   CI_ERR_WORD     word reported on m_data after a slave timeout (sliced to DATA_W)
//   ci_state_e      master FSM states
//   ctr_width()     counter width able to hold 0..limit
package ci_master_pkg;

   localparam int CI_DATA_W_DEF  = 32;
   localparam int CI_TIMEOUT_DEF = 64;
   localparam int CI_OP_CNT_W    = 16;
   localparam int CI_ERR_WORD_W  = 64;

   localparam logic [CI_ERR_WORD_W-1:0] CI_ERR_WORD = '1;

`ifdef CI_TIMEOUT_EN
   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_ISSUE = 3'd1,
      ST_WAIT  = 3'd2,
      ST_HOLD  = 3'd3,
      ST_ERR   = 3'd4
   } ci_state_e;
`else
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_HOLD  = 2'd3
   } ci_state_e;
`endif

   function automatic int ctr_width(input int limit);
      return ($clog2(limit + 1) < 1) ? 1 : $clog2(limit + 1);
   endfunction

endpackage

// File: rtl/ci_sample_master_if.sv
// rtl/ci_sample_master_if.sv - custom-instruction bus between ci_sample_master and its slave
// Signals:
//   ci_clk_en  master->slave  clock enable for the slave datapath
//   ci_start   master->slave  one-cycle start pulse
//   ci_dataa   master->slave  operand A (sample)
//   ci_datab   master->slave  operand B (cfg_b latched at accept)
//   ci_result  slave->master  result word
//   ci_done    slave->master  completion strobe
interface ci_sample_master_if
   import ci_master_pkg::*;
#(
   parameter int DATA_W = CI_DATA_W_DEF
);

   logic              ci_clk_en;
   logic              ci_start;
   logic [DATA_W-1:0] ci_dataa;
   logic [DATA_W-1:0] ci_datab;
   logic [DATA_W-1:0] ci_result;
   logic              ci_done;

   modport master (
      output ci_clk_en,
      output ci_start,
      output ci_dataa,
      output ci_datab,
      input  ci_result,
      input  ci_done
   );

   modport slave (
      input  ci_clk_en,
      input  ci_start,
      input  ci_dataa,
      input  ci_datab,
      output ci_result,
      output ci_done
   );

endinterface

// File: rtl/ci_sample_master_timeout_ctr.sv
// rtl/ci_sample_master_timeout_ctr.sv - WAIT-cycle watchdog used by ci_sample_master under CI_TIMEOUT_EN
// Ports:
//   clk, reset_n  clock, asynchronous active-low reset
//   load          clear the count (asserted in the ISSUE cycle)
//   enable        count one WAIT cycle
//   expire        high during the LIMIT-th consecutive enabled cycle
module ci_timeout_ctr
   import ci_master_pkg::*;
#(
   parameter int LIMIT = CI_TIMEOUT_DEF
) (
   input  logic clk,
   input  logic reset_n,
   input  logic load,
   input  logic enable,
   output logic expire
);

   localparam int CW = ctr_width(LIMIT);

   logic [CW-1:0] cnt_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q <= '0;
      end else if (load) begin
         cnt_q <= '0;
      end else if (enable && !expire) begin
         cnt_q <= cnt_q + CW'(1);
      end
   end

   // The count holds the number of WAIT cycles already completed, so it
   // equals LIMIT-1 during the LIMIT-th one; the FSM leaves WAIT on that edge.
   assign expire = enable && (cnt_q == CW'(LIMIT - 1));

endmodule

// File: rtl/ci_sample_master.sv
// rtl/ci_sample_master.sv - feeds audio samples one at a time through a custom-instruction slave
// Optional feature macro: CI_TIMEOUT_EN (watchdog on WAIT, ERR state reporting CI_ERR_WORD).
// Ports:
//   clk, reset_n              clock, asynchronous active-low reset
//   s_data/s_valid/s_ready    sample input stream
//   cfg_b                     operand B, latched with each accepted sample
//   ci                        custom-instruction bus (master modport)
//   m_data/m_valid/m_ready    result output stream
//   busy                      high whenever the FSM is not IDLE
//   op_count                  completed operations, wraps at 16 bits
module ci_sample_master
   import ci_master_pkg::*;
#(
   parameter int DATA_W      = CI_DATA_W_DEF,
   parameter int TIMEOUT_CYC = CI_TIMEOUT_DEF
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic [DATA_W-1:0]      s_data,
   input  logic                   s_valid,
   output logic                   s_ready,
   input  logic [DATA_W-1:0]      cfg_b,
   ci_sample_master_if.master     ci,
   output logic [DATA_W-1:0]      m_data,
   output logic                   m_valid,
   input  logic                   m_ready,
   output logic                   busy,
   output logic [CI_OP_CNT_W-1:0] op_count
);

   if (TIMEOUT_CYC < 1) begin : g_bad_timeout
      $error("ci_sample_master: TIMEOUT_CYC must be at least 1");
   end

   if (DATA_W < 1 || DATA_W > CI_ERR_WORD_W) begin : g_bad_width
      $error("ci_sample_master: DATA_W out of range");
   end

   ci_state_e state;

`ifdef CI_TIMEOUT_EN
   logic to_load;
   logic to_enable;
   logic to_expire;

   assign to_load   = (state == ST_ISSUE);
   assign to_enable = (state == ST_WAIT);

   ci_timeout_ctr #(
      .LIMIT (TIMEOUT_CYC)
   ) u_timeout_ctr (
      .clk     (clk),
      .reset_n (reset_n),
      .load    (to_load),
      .enable  (to_enable),
      .expire  (to_expire)
   );
`endif

   // All outputs are registered and set on the edge that enters their
   // state, so each output already reflects the state it belongs to.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state        <= ST_IDLE;
         s_ready      <= 1'b0;
         ci.ci_clk_en <= 1'b0;
         ci.ci_start  <= 1'b0;
         ci.ci_dataa  <= '0;
         ci.ci_datab  <= '0;
         m_data       <= '0;
         m_valid      <= 1'b0;
         busy         <= 1'b0;
         op_count     <= '0;
      end else begin
         ci.ci_start <= 1'b0;

         case (state)
            ST_IDLE: begin
               s_ready <= 1'b1;
               if (s_valid && s_ready) begin
                  ci.ci_dataa  <= s_data;
                  ci.ci_datab  <= cfg_b;
                  ci.ci_start  <= 1'b1;
                  ci.ci_clk_en <= 1'b1;
                  s_ready      <= 1'b0;
                  busy         <= 1'b1;
                  state        <= ST_ISSUE;
               end
            end

            // A zero-wait slave answers in the ISSUE cycle itself, so ISSUE
            // and WAIT share the capture path.
            ST_ISSUE, ST_WAIT: begin
               if (ci.ci_done) begin
                  m_data       <= ci.ci_result;
                  m_valid      <= 1'b1;
                  ci.ci_clk_en <= 1'b0;
                  state        <= ST_HOLD;
               end
`ifdef CI_TIMEOUT_EN
               else if (to_expire) begin
                  m_data       <= CI_ERR_WORD[DATA_W-1:0];
                  m_valid      <= 1'b1;
                  ci.ci_clk_en <= 1'b0;
                  state        <= ST_ERR;
               end
`endif
               else begin
                  state <= ST_WAIT;
               end
            end

            ST_HOLD: begin
               if (m_ready) begin
                  m_valid  <= 1'b0;
                  busy     <= 1'b0;
                  s_ready  <= 1'b1;
                  op_count <= op_count + CI_OP_CNT_W'(1);
                  state    <= ST_IDLE;
               end
            end

`ifdef CI_TIMEOUT_EN
            // Same handshake as HOLD, but a timed-out operation is not counted.
            ST_ERR: begin
               if (m_ready) begin
                  m_valid <= 1'b0;
                  busy    <= 1'b0;
                  s_ready <= 1'b1;
                  state   <= ST_IDLE;
               end
            end
`endif

            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ci_sample_master.sv
// tb/tb_ci_sample_master.sv - randomized self-checking bench for ci_sample_master
module tb_ci_sample_master;

   localparam int DW = 32;
   localparam int TO = 8;

   logic          clk = 1'b0;
   logic          reset_n;
   logic [DW-1:0] s_data;
   logic          s_valid;
   logic          s_ready;
   logic [DW-1:0] cfg_b;
   logic [DW-1:0] m_data;
   logic          m_valid;
   logic          m_ready;
   logic          busy;
   logic [15:0]   op_count;

   int            n_checks = 0;
   int            n_fail   = 0;
   int            ops_done = 0;
   bit            fixed_mode = 1'b0;
   logic [DW-1:0] fixed_val  = '0;

   ci_sample_master_if #(.DATA_W(DW)) ci_bus ();

   ci_sample_master #(
      .DATA_W      (DW),
      .TIMEOUT_CYC (TO)
   ) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .s_data   (s_data),
      .s_valid  (s_valid),
      .s_ready  (s_ready),
      .cfg_b    (cfg_b),
      .ci       (ci_bus),
      .m_data   (m_data),
      .m_valid  (m_valid),
      .m_ready  (m_ready),
      .busy     (busy),
      .op_count (op_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // The slave's arithmetic contract.
   function automatic logic [DW-1:0] slave_fn(input logic [DW-1:0] a, input logic [DW-1:0] b);
      return (a * 32'd3) ^ {b[15:0], b[31:16]};
   endfunction

   task automatic check_reset_outputs(input string tag, input logic exp_ready);
      check({tag, "_s_ready"},   s_ready,          exp_ready);
      check({tag, "_ci_clk_en"}, ci_bus.ci_clk_en, 0);
      check({tag, "_ci_start"},  ci_bus.ci_start,  0);
      check({tag, "_ci_dataa"},  ci_bus.ci_dataa,  0);
      check({tag, "_ci_datab"},  ci_bus.ci_datab,  0);
      check({tag, "_m_data"},    m_data,           0);
      check({tag, "_m_valid"},   m_valid,          0);
      check({tag, "_busy"},      busy,             0);
      check({tag, "_op_count"},  op_count,         0);
   endtask

   // One full operation; called and returning at a negedge while the DUT is IDLE.
   // wait_n: slave cycles after the ISSUE cycle before ci_done (0 = done in ISSUE).
   task automatic do_op(input logic [DW-1:0] smp, input logic [DW-1:0] cfg,
                        input int wait_n, input int hold_n, input bit expect_err);
      logic [DW-1:0] exp_res;
      int            exp_k;
      int            lat_k;
      int            en_cnt;
      int            st_cnt;
      int            unstable;
      int            hold_bad;
      int            stray_at;
      int            guard;
      bit            got;

      exp_res = expect_err ? {DW{1'b1}} : (fixed_mode ? fixed_val : slave_fn(smp, cfg));
      exp_k   = (expect_err ? TO : wait_n) + 1;

      s_data  = smp;
      cfg_b   = cfg;
      s_valid = 1'b1;
      guard   = 0;
      while (!s_ready && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      check("accept_ready", s_ready, 1);
      @(negedge clk);

      // Keep offering junk while busy: none of it may be accepted.
      s_data   = $urandom;
      cfg_b    = $urandom;
      en_cnt   = 0;
      st_cnt   = 0;
      unstable = 0;
      lat_k    = -1;
      got      = 1'b0;
      for (int k = 0; k < 200; k++) begin
         if (m_valid) begin
            got   = 1'b1;
            lat_k = k;
            break;
         end
         if (ci_bus.ci_clk_en) en_cnt++;
         if (ci_bus.ci_start) st_cnt++;
         if (ci_bus.ci_dataa !== smp || ci_bus.ci_datab !== cfg || s_ready !== 1'b0 || busy !== 1'b1)
            unstable++;
         if (!expect_err && k == wait_n) begin
            ci_bus.ci_done   = 1'b1;
            ci_bus.ci_result = fixed_mode ? fixed_val : slave_fn(ci_bus.ci_dataa, ci_bus.ci_datab);
         end else begin
            ci_bus.ci_done   = 1'b0;
            ci_bus.ci_result = $urandom;
         end
         @(negedge clk);
      end
      ci_bus.ci_done = 1'b0;

      check("m_valid_seen", got, 1);
      check("accept_to_valid_cycles", lat_k + 1, exp_k + 1);
      check("ci_clk_en_cycles", en_cnt, exp_k);
      check("ci_start_pulses", st_cnt, 1);
      check("operands_stable", unstable, 0);
      check("m_data", m_data, exp_res);

      // Stalled output; a stray ci_done here must be ignored.
      stray_at = (hold_n > 0) ? $urandom_range(0, hold_n - 1) : -1;
      hold_bad = 0;
      for (int h = 0; h < hold_n; h++) begin
         ci_bus.ci_done   = (h == stray_at);
         ci_bus.ci_result = $urandom;
         @(negedge clk);
         if (m_valid !== 1'b1 || m_data !== exp_res || s_ready !== 1'b0 ||
             ci_bus.ci_clk_en !== 1'b0 || ci_bus.ci_start !== 1'b0)
            hold_bad++;
      end
      ci_bus.ci_done = 1'b0;
      check("hold_stable", hold_bad, 0);

      m_ready = 1'b1;
      @(negedge clk);
      m_ready = 1'b0;
      s_valid = 1'b0;
      if (!expect_err) ops_done++;
      check("m_valid_released", m_valid, 0);
      check("op_count", op_count, ops_done % 65536);
      check("busy_after_op", busy, 0);
      check("s_ready_after_op", s_ready, 1);
   endtask

   task automatic reset_mid_wait();
      int bad;
      s_data  = $urandom;
      cfg_b   = $urandom;
      s_valid = 1'b1;
      @(negedge clk);
      s_valid = 1'b0;
      // ISSUE then two WAIT cycles with a silent slave.
      repeat (3) @(negedge clk);
      check("busy_before_reset", busy, 1);
      #2 reset_n = 1'b0;
      #1 check_reset_outputs("async_rst", 1'b0);
      ops_done = 0;
      @(negedge clk);
      reset_n = 1'b1;
      // Late completion from the aborted slave.
      bad = 0;
      for (int i = 0; i < 4; i++) begin
         ci_bus.ci_done   = 1'b1;
         ci_bus.ci_result = $urandom;
         @(negedge clk);
         if (m_valid !== 1'b0) bad++;
      end
      ci_bus.ci_done = 1'b0;
      check("late_done_ignored", bad, 0);
      check_reset_outputs("after_abort", 1'b1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached, got %0d checks, expected summary before limit", n_checks);
      $fatal(1);
   end

   initial begin
      reset_n          = 1'b0;
      s_valid          = 1'b0;
      s_data           = '0;
      cfg_b            = '0;
      m_ready          = 1'b0;
      ci_bus.ci_done   = 1'b0;
      ci_bus.ci_result = '0;

      repeat (3) @(negedge clk);
      check_reset_outputs("rst_low", 1'b0);
      reset_n = 1'b1;
      @(negedge clk);
      check("s_ready_after_rst", s_ready, 1);

      // Known vector: slave done 3 cycles after start.
      fixed_mode = 1'b1;
      fixed_val  = 32'h0000_0123;
      do_op(32'h0000_1234, $urandom, 3, 2, 1'b0);
      fixed_mode = 1'b0;

      // Long output stall.
      do_op($urandom, $urandom, $urandom_range(0, 5), 10, 1'b0);

      // Random waits and stalls.
      repeat (24) do_op($urandom, $urandom, $urandom_range(0, TO - 2), $urandom_range(0, 4), 1'b0);

      // Zero-wait slave, back-to-back.
      repeat (16) do_op($urandom, $urandom, 0, 0, 1'b0);

`ifdef CI_TIMEOUT_EN
      do_op($urandom, $urandom, 0, 3, 1'b1);
`else
      do_op($urandom, $urandom, 3 * TO, 1, 1'b0);
`endif

      reset_mid_wait();
      do_op($urandom, $urandom, 1, 1, 1'b0);

      // Counter wrap from a preloaded 0xFFFF.
      force dut.op_count = 16'hFFFF;
      @(negedge clk);
      release dut.op_count;
      ops_done = 65535;
      @(negedge clk);
      check("op_count_preload", op_count, 16'hFFFF);
      do_op($urandom, $urandom, 1, 0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/ci_sample_master.md
CI_SAMPLE_MASTER -- requirements
Module: ci_sample_master

Interface
REQ-001 SHALL have parameter DATA_W, default 32, width of samples, CI operands and results.
REQ-002 SHALL have parameter TIMEOUT_CYC, default 64, max cycles waited for ci_done after ci_start.
REQ-003 SHALL have port clk input 1, single clock for all logic.
REQ-004 SHALL have port reset_n input 1, asynchronous active-low reset.
REQ-005 SHALL have port s_data input DATA_W, input audio sample.
REQ-006 SHALL have port s_valid input 1, s_data valid.
REQ-007 SHALL have port s_ready output 1, block accepts sample this cycle.
REQ-008 SHALL have port cfg_b input DATA_W, value driven on ci_datab for every operation.
REQ-009 SHALL have port ci_clk_en output 1, custom-instruction clock enable to slave.
REQ-010 SHALL have port ci_start output 1, one-cycle start pulse to slave.
REQ-011 SHALL have port ci_dataa output DATA_W, operand A (sample).
REQ-012 SHALL have port ci_datab output DATA_W, operand B (cfg_b, latched at accept).
REQ-013 SHALL have port ci_result input DATA_W, slave result.
REQ-014 SHALL have port ci_done input 1, slave completion strobe.
REQ-015 SHALL have port m_data output DATA_W, captured result.
REQ-016 SHALL have port m_valid output 1, m_data valid.
REQ-017 SHALL have port m_ready input 1, downstream accepts m_data.
REQ-018 SHALL have port busy output 1, high in any state except IDLE.
REQ-019 SHALL have port op_count output 16, completed operations, wraps 0xFFFF->0.

Function
REQ-020 SHALL implement states IDLE, ISSUE, WAIT, HOLD (ERR with CI_TIMEOUT_EN).
REQ-021 IDLE: s_ready=1; on s_valid&s_ready latch s_data->ci_dataa, cfg_b->ci_datab, go ISSUE next cycle.
REQ-022 ISSUE: ci_start=1 and ci_clk_en=1 for exactly one cycle, then WAIT.
REQ-023 WAIT: ci_clk_en=1 every cycle, ci_start=0; on ci_done=1 capture ci_result into m_data same edge, go HOLD.
REQ-024 ci_done during ISSUE (zero-wait slave) SHALL be captured identically and go HOLD directly.
REQ-025 HOLD: m_valid=1, ci_clk_en=0, m_data stable; on m_ready go IDLE and op_count+1.
REQ-026 s_ready SHALL be 0 in ISSUE, WAIT, HOLD, ERR; no sample dropped or duplicated.
REQ-027 ci_dataa/ci_datab SHALL stay stable from ISSUE until leaving WAIT.
REQ-028 ci_done outside ISSUE/WAIT SHALL be ignored.
REQ-029 Minimum accept-to-m_valid latency SHALL be 2 cycles plus slave wait cycles.

Reset
REQ-030 reset_n low SHALL asynchronously force IDLE, s_ready=0 while low then 1, ci_clk_en=0, ci_start=0, ci_dataa=0, ci_datab=0, m_data=0, m_valid=0, busy=0, op_count=0.
REQ-031 Reset mid-operation SHALL abort without emitting m_valid; a later ci_done from slave SHALL be ignored.

Configuration
REQ-032 Macro CI_TIMEOUT_EN defined: WAIT counter reaches TIMEOUT_CYC without ci_done -> ERR; ERR drives m_data=all-ones, m_valid=1, behaves as HOLD, op_count not incremented.
REQ-033 Macro CI_TIMEOUT_EN undefined: no counter, no ERR state, WAIT holds indefinitely.

Structure
REQ-034 Package ci_master_pkg SHALL hold state enum, CI_ERR_WORD constant, default widths.
REQ-035 Sub-module ci_timeout_ctr (load, enable, expire) SHALL be instantiated only under CI_TIMEOUT_EN.

Verification
REQ-036 Sample 0x0000_1234, slave done after 3 cycles returning 0x0000_0123 -> one ci_start pulse, ci_clk_en high 4 cycles, m_data=0x0000_0123, op_count=1.
REQ-037 m_ready held low 10 cycles in HOLD -> m_data stable, s_ready=0, s_valid samples not accepted.
REQ-038 Zero-wait slave (done in ISSUE cycle) on 16 back-to-back samples -> 16 results in order, op_count=16.
REQ-039 reset_n low during WAIT, slave then asserts done -> no m_valid, all outputs at reset values.
REQ-040 CI_TIMEOUT_EN, TIMEOUT_CYC=8, slave never done -> ERR after 8 WAIT cycles, m_data=0xFFFF_FFFF, op_count unchanged.
REQ-041 op_count preloaded at 0xFFFF by 65535 ops, one more op -> op_count=0x0000.
